// File: rtl/imm_extender_seq_pkg.sv
// -----------------------------------------------------------------------------
// imm_extender_seq_pkg
// Shared definitions for the registered immediate extender:
//   - mode_e      : operation encodings carried on MODE
//   - pfx_state_e : prefix-chain occupancy (EMPTY / PARTIAL / FULL)
//   - max_pfx()   : number of prefix chunks that fit ahead of the last field
//   - cnt_w()     : width of the prefix-chunk counter
// -----------------------------------------------------------------------------
package imm_extender_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ZE  = 2'b00,
        MODE_SE  = 2'b01,
        MODE_HI  = 2'b10,
        MODE_PFX = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } pfx_state_e;

    // The final (non-prefix) field always occupies one chunk, so the
    // chain can hold one chunk fewer than the output has room for.
    function automatic int max_pfx(input int in_w, input int out_w);
        return out_w / in_w - 1;
    endfunction

    function automatic int cnt_w(input int in_w, input int out_w);
        return $clog2(max_pfx(in_w, out_w) + 1);
    endfunction

endpackage

// File: rtl/imm_extender_seq_if.sv
// -----------------------------------------------------------------------------
// imm_extender_seq_if
// Bundles the pipeline-facing signals of the immediate extender.
//   master : decode stage side (drives STALL/FLUSH/IN_VALID/MODE/INPUT)
//   slave  : the extender (drives OUTPUT/OUT_VALID/PFX_CNT/PFX_OVF/PFX_DROP)
// Parameters IN_W / OUT_W must match those of the attached extender.
// -----------------------------------------------------------------------------
interface imm_extender_seq_if
    import imm_extender_seq_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) ();

    localparam int CNT_W = cnt_w(IN_W, OUT_W);

    logic             STALL;
    logic             FLUSH;
    logic             IN_VALID;
    logic [1:0]       MODE;
    logic [IN_W-1:0]  INPUT;
    logic [OUT_W-1:0] OUTPUT;
    logic             OUT_VALID;
    logic [CNT_W-1:0] PFX_CNT;
    logic             PFX_OVF;
    logic             PFX_DROP;

    modport master (
        output STALL, FLUSH, IN_VALID, MODE, INPUT,
        input  OUTPUT, OUT_VALID, PFX_CNT, PFX_OVF, PFX_DROP
    );

    modport slave (
        input  STALL, FLUSH, IN_VALID, MODE, INPUT,
        output OUTPUT, OUT_VALID, PFX_CNT, PFX_OVF, PFX_DROP
    );

endinterface

// File: rtl/imm_extender_seq_ext_core.sv
// -----------------------------------------------------------------------------
// imm_extender_seq_ext_core
// Combinational extension of a chained immediate.
//   v_i      : concatenated value {prefix chunks, field}, right-aligned
//   n_i      : number of prefix chunks in v_i (valid width is (n_i+1)*IN_W)
//   mode_i   : ZE / SE / HI (PFX treated as ZE; its result is never used)
//   result_o : OUT_W extended result
// -----------------------------------------------------------------------------
module imm_extender_seq_ext_core
    import imm_extender_seq_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int CNT_W = 1
) (
    input  logic [OUT_W-1:0] v_i,
    input  logic [CNT_W-1:0] n_i,
    input  mode_e            mode_i,
    output logic [OUT_W-1:0] result_o
);

    localparam int NCH = OUT_W / IN_W;

    logic [OUT_W-1:0] mask;
    logic [NCH-1:0]   chunk_msb;
    logic             sign;

    // Chunk gi is part of the value when it lies at or below chunk n_i;
    // the msb of chunk n_i is the sign bit of the whole chained value.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
            assign mask[gi*IN_W +: IN_W] = (int'(n_i) >= gi) ? {IN_W{1'b1}} : {IN_W{1'b0}};
            assign chunk_msb[gi]         = v_i[gi*IN_W + IN_W - 1];
        end
    endgenerate

    always_comb begin
        sign = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(n_i) == k) begin
                sign = chunk_msb[k];
            end
        end
    end

    always_comb begin
        result_o = v_i & mask;
        unique case (mode_i)
            MODE_SE: result_o = (v_i & mask) | (sign ? ~mask : {OUT_W{1'b0}});
            MODE_HI: result_o = {v_i[IN_W-1:0], {(OUT_W-IN_W){1'b0}}};
            default: result_o = v_i & mask;
        endcase
    end

endmodule

// File: rtl/imm_extender_seq.sv
// -----------------------------------------------------------------------------
// imm_extender_seq
// Registered immediate extender sitting between decode and the ALU B-mux.
// Supports zero-extend, sign-extend, high-place and prefix chaining, where
// successive PREFIX ops shift narrow chunks into an accumulator that the
// next ZE/SE op consumes as the upper part of a wider constant.
//   CLK, RESET : clock and synchronous active-high reset
//   bus        : slave side of imm_extender_seq_if (stall/flush, op in,
//                registered result, prefix count and event pulses out)
// Results appear one edge after an op is accepted (IN_VALID & ~STALL).
// OUT_W must be a multiple of IN_W and larger than IN_W.
// -----------------------------------------------------------------------------
module imm_extender_seq
    import imm_extender_seq_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input logic                CLK,
    input logic                RESET,
    imm_extender_seq_if.slave  bus
);

    localparam int MAX_PFX = max_pfx(IN_W, OUT_W);
    localparam int ACC_W   = MAX_PFX * IN_W;
    localparam int CNT_W   = cnt_w(IN_W, OUT_W);

    logic [ACC_W-1:0] acc_q, acc_d, acc_eff;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;
    pfx_state_e       state_q, state_d, state_eff;
    logic [OUT_W-1:0] out_q, out_d, core_res;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             drop_q, drop_d;

    mode_e            mode;
    logic             accept;

    assign mode   = mode_e'(bus.MODE);
    assign accept = bus.IN_VALID & ~bus.STALL;

    // FLUSH wipes the chain before anything else looks at it, so an op in
    // the same cycle sees an empty prefix and a stalled flush still clears.
    assign acc_eff   = bus.FLUSH ? {ACC_W{1'b0}} : acc_q;
    assign cnt_eff   = bus.FLUSH ? {CNT_W{1'b0}} : cnt_q;
    assign state_eff = bus.FLUSH ? EMPTY : state_q;

    // Upper accumulator chunks beyond cnt_eff are always zero, and the core
    // masks them anyway, so the full accumulator can be passed through.
    imm_extender_seq_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) u_ext_core (
        .v_i      ({acc_eff, bus.INPUT}),
        .n_i      (cnt_eff),
        .mode_i   (mode),
        .result_o (core_res)
    );

    always_comb begin
        acc_d   = acc_eff;
        cnt_d   = cnt_eff;
        out_d   = out_q;
        valid_d = 1'b0;
        ovf_d   = 1'b0;
        drop_d  = 1'b0;

        if (accept) begin
            if (mode == MODE_PFX) begin
                // Shift in at the LSB end; when full the oldest chunk
                // falls off the top and the count stays put.
                acc_d = ACC_W'({acc_eff, bus.INPUT});
                if (state_eff == FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_eff + CNT_W'(1);
                end
            end else begin
                out_d   = core_res;
                valid_d = 1'b1;
                drop_d  = (mode == MODE_HI) && (cnt_eff != '0);
                acc_d   = {ACC_W{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        end

        if (cnt_d == '0) begin
            state_d = EMPTY;
        end else if (cnt_d == CNT_W'(MAX_PFX)) begin
            state_d = FULL;
        end else begin
            state_d = PARTIAL;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= EMPTY;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.OUTPUT    = out_q;
    assign bus.OUT_VALID = valid_q;
    assign bus.PFX_CNT   = cnt_q;
    assign bus.PFX_OVF   = ovf_q;
    assign bus.PFX_DROP  = drop_q;

endmodule

// File: tb/tb_imm_extender_seq.sv
module tb_imm_extender_seq;

    localparam logic [1:0] ZE  = 2'b00;
    localparam logic [1:0] SE  = 2'b01;
    localparam logic [1:0] HI  = 2'b10;
    localparam logic [1:0] PFX = 2'b11;

    typedef struct {
        int          cyc;
        logic [31:0] out;
        bit          v;
        bit          o;
        bit          d;
    } exp_t;

    logic CLK;
    logic RESET;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t q16[$];
    exp_t q32[$];

    imm_extender_seq_if #(.IN_W(8), .OUT_W(16)) bus16 ();
    imm_extender_seq_if #(.IN_W(8), .OUT_W(32)) bus32 ();

    imm_extender_seq #(.IN_W(8), .OUT_W(16)) dut16 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus16.slave)
    );

    imm_extender_seq #(.IN_W(8), .OUT_W(32)) dut32 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus32.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end else begin
            $display("[TB] ok   %s = 0x%0h", name, act);
        end
    endtask

    // Drive one accepted op on the chosen DUT and queue its expected pulses.
    task automatic op(input bit w32, input logic [1:0] m, input logic [7:0] d,
                      input bit fl, input logic [31:0] eo,
                      input bit ev, input bit eovf, input bit edrop);
        exp_t e;
        e.cyc = cyc + 1; e.out = eo; e.v = ev; e.o = eovf; e.d = edrop;
        if (w32) begin
            bus32.IN_VALID = 1'b1; bus32.MODE = m; bus32.INPUT = d; bus32.FLUSH = fl;
            if (ev || eovf || edrop) q32.push_back(e);
        end else begin
            bus16.IN_VALID = 1'b1; bus16.MODE = m; bus16.INPUT = d; bus16.FLUSH = fl;
            if (ev || eovf || edrop) q16.push_back(e);
        end
        @(posedge CLK); #1;
        bus16.IN_VALID = 1'b0; bus16.FLUSH = 1'b0;
        bus32.IN_VALID = 1'b0; bus32.FLUSH = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    // Scoreboard monitor: every pulse the DUT presents must match the head
    // of the queue, including the cycle on which it was promised.
    task automatic mon(input string tag, input bit v, input bit o, input bit d,
                       input logic [31:0] out, inout exp_t q[$]);
        exp_t e;
        bit   ok;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("[TB] FAIL %s unexpected pulse cyc=%0d v=%0b ovf=%0b drop=%0b out=0x%0h, required none",
                     tag, cyc, v, o, d, out);
            return;
        end
        e  = q.pop_front();
        ok = (e.cyc == cyc) && (e.v == v) && (e.o == o) && (e.d == d) && (!e.v || (e.out == out));
        if (!ok) begin
            fails++;
            $display("[TB] FAIL %s txn: got cyc=%0d v=%0b ovf=%0b drop=%0b out=0x%0h, required cyc=%0d v=%0b ovf=%0b drop=%0b out=0x%0h",
                     tag, cyc, v, o, d, out, e.cyc, e.v, e.o, e.d, e.out);
        end else begin
            $display("[TB] %s txn cyc=%0d v=%0b ovf=%0b drop=%0b out=0x%0h ok", tag, cyc, v, o, d, out);
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            if (bus16.OUT_VALID || bus16.PFX_OVF || bus16.PFX_DROP)
                mon("dut16", bus16.OUT_VALID, bus16.PFX_OVF, bus16.PFX_DROP, {16'h0, bus16.OUTPUT}, q16);
            if (bus32.OUT_VALID || bus32.PFX_OVF || bus32.PFX_DROP)
                mon("dut32", bus32.OUT_VALID, bus32.PFX_OVF, bus32.PFX_DROP, bus32.OUTPUT, q32);
        end
    end

    initial begin
        RESET = 1'b1;
        bus16.STALL = 1'b0; bus16.FLUSH = 1'b0; bus16.IN_VALID = 1'b0; bus16.MODE = ZE; bus16.INPUT = 8'h00;
        bus32.STALL = 1'b0; bus32.FLUSH = 1'b0; bus32.IN_VALID = 1'b0; bus32.MODE = ZE; bus32.INPUT = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("rst16_out",   {16'h0, bus16.OUTPUT}, 32'h0);
        chk("rst16_valid", {31'h0, bus16.OUT_VALID}, 32'h0);
        chk("rst16_cnt",   {31'h0, bus16.PFX_CNT}, 32'h0);
        chk("rst32_out",   bus32.OUTPUT, 32'h0);
        chk("rst32_cnt",   {30'h0, bus32.PFX_CNT}, 32'h0);

        // Back-to-back ZE / SE / HI
        op(0, ZE, 8'hAA, 0, 32'h00AA, 1, 0, 0);
        op(0, SE, 8'hAA, 0, 32'hFFAA, 1, 0, 0);
        op(0, HI, 8'h47, 0, 32'h4700, 1, 0, 0);
        idle(1);

        // Prefix then ZE
        op(0, PFX, 8'h12, 0, 32'h0, 0, 0, 0);
        chk("pfx_cnt_after_prefix", {31'h0, bus16.PFX_CNT}, 32'h1);
        op(0, ZE, 8'h34, 0, 32'h1234, 1, 0, 0);
        chk("pfx_cnt_after_ze", {31'h0, bus16.PFX_CNT}, 32'h0);

        // Overflow: second prefix pushes the first out
        op(0, PFX, 8'h11, 0, 32'h0, 0, 0, 0);
        op(0, PFX, 8'h22, 0, 32'h0, 0, 1, 0);
        chk("ovf_cnt_stays", {31'h0, bus16.PFX_CNT}, 32'h1);
        op(0, ZE, 8'h33, 0, 32'h2233, 1, 0, 0);

        // HI discards prefix
        op(0, PFX, 8'h55, 0, 32'h0, 0, 0, 0);
        op(0, HI, 8'h01, 0, 32'h0100, 1, 0, 1);

        // FLUSH with a same-cycle op
        op(0, PFX, 8'h55, 0, 32'h0, 0, 0, 0);
        op(0, ZE, 8'h01, 1, 32'h0001, 1, 0, 0);

        // FLUSH while stalled clears the chain but leaves OUTPUT alone
        op(0, PFX, 8'h66, 0, 32'h0, 0, 0, 0);
        bus16.STALL = 1'b1; bus16.FLUSH = 1'b1;
        idle(1);
        bus16.STALL = 1'b0; bus16.FLUSH = 1'b0;
        chk("stall_flush_cnt", {31'h0, bus16.PFX_CNT}, 32'h0);
        chk("stall_flush_out", {16'h0, bus16.OUTPUT}, 32'h0001);
        op(0, SE, 8'h81, 0, 32'hFF81, 1, 0, 0);

        // STALL held over a pending ZE
        op(0, PFX, 8'h12, 0, 32'h0, 0, 0, 0);
        bus16.STALL = 1'b1; bus16.IN_VALID = 1'b1; bus16.MODE = ZE; bus16.INPUT = 8'h34;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("stall_cnt_hold", {31'h0, bus16.PFX_CNT}, 32'h1);
            chk("stall_out_hold", {16'h0, bus16.OUTPUT}, 32'hFF81);
        end
        bus16.STALL = 1'b0;
        q16.push_back('{cyc: cyc + 1, out: 32'h1234, v: 1'b1, o: 1'b0, d: 1'b0});
        idle(1);
        bus16.IN_VALID = 1'b0;

        // RESET mid-chain
        op(0, PFX, 8'h77, 0, 32'h0, 0, 0, 0);
        chk("mid_chain_cnt", {31'h0, bus16.PFX_CNT}, 32'h1);
        RESET = 1'b1;
        idle(1);
        RESET = 1'b0;
        chk("reset_mid_cnt", {31'h0, bus16.PFX_CNT}, 32'h0);
        chk("reset_mid_out", {16'h0, bus16.OUTPUT}, 32'h0);
        op(0, ZE, 8'h05, 0, 32'h0005, 1, 0, 0);

        // 32-bit instance
        op(1, PFX, 8'h80, 0, 32'h0, 0, 0, 0);
        op(1, SE,  8'h01, 0, 32'hFFFF8001, 1, 0, 0);
        op(1, PFX, 8'h80, 0, 32'h0, 0, 0, 0);
        op(1, ZE,  8'h01, 0, 32'h00008001, 1, 0, 0);
        op(1, PFX, 8'h12, 0, 32'h0, 0, 0, 0);
        op(1, PFX, 8'h34, 0, 32'h0, 0, 0, 0);
        op(1, PFX, 8'h56, 0, 32'h0, 0, 0, 0);
        chk("cnt32_full", {30'h0, bus32.PFX_CNT}, 32'h3);
        op(1, ZE,  8'h78, 0, 32'h12345678, 1, 0, 0);
        op(1, PFX, 8'hA1, 0, 32'h0, 0, 0, 0);
        op(1, PFX, 8'hB2, 0, 32'h0, 0, 0, 0);
        op(1, PFX, 8'hC3, 0, 32'h0, 0, 0, 0);
        op(1, PFX, 8'hD4, 0, 32'h0, 0, 1, 0);
        op(1, SE,  8'h85, 0, 32'hB2C3D485, 1, 0, 0);
        op(1, PFX, 8'h9A, 0, 32'h0, 0, 0, 0);
        op(1, SE,  8'h01, 0, 32'hFFFF9A01, 1, 0, 0);

        idle(3);
        chk("q16_drained", q16.size(), 32'h0);
        chk("q32_drained", q32.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imm_extender_seq.md
Name: imm_extender_seq

Overview:
- Parametrised, registered immediate-extension unit for the 16-bit datapath; next generation of the combinational 8→16 zero-extender.
- Supports four modes: zero-extend, sign-extend, high-place, and prefix chaining.
- Prefix chaining lets successive narrow immediates be concatenated into one wide constant.
- Sits between instruction decode and the ALU B-mux; honours pipeline stall and flush.

Parameters:
- IN_W, 8: immediate field width in bits.
- OUT_W, 16: output width; must be a multiple of IN_W and greater than IN_W.
- MAX_PFX, OUT_W/IN_W-1 (derived localparam): maximum number of held prefix chunks.

Ports:
- CLK  in  1  sole clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- STALL  in  1  freeze all state and outputs.
- FLUSH  in  1  discard any pending prefix chunks.
- IN_VALID  in  1  INPUT/MODE carry an operation this cycle.
- MODE  in  2  operation: 00 ZE, 01 SE, 10 HI, 11 PREFIX.
- INPUT  in  IN_W  immediate field.
- OUTPUT  out  OUT_W  registered extended result.
- OUT_VALID  out  1  one-cycle pulse: OUTPUT updated by the previous accepted op.
- PFX_CNT  out  clog2(MAX_PFX+1)  number of prefix chunks held.
- PFX_OVF  out  1  one-cycle pulse: PREFIX issued while full.
- PFX_DROP  out  1  one-cycle pulse: HI op discarded pending prefix chunks.

Behaviour:
- Reset (CLK edge with RESET=1): OUTPUT=0, OUT_VALID=0, PFX_CNT=0, accumulator=0, PFX_OVF=0, PFX_DROP=0, state EMPTY.
- Priority is RESET > FLUSH > STALL > IN_VALID.
- FLUSH:
  - Clears the accumulator and count (state EMPTY) even while STALL=1.
  - If STALL=0 and IN_VALID=1 in the same cycle, the op executes with an empty prefix.
  - OUTPUT is unchanged by FLUSH itself.
- STALL=1: OUTPUT, PFX_CNT and accumulator hold; the op is ignored; OUT_VALID, PFX_OVF and PFX_DROP are driven 0.
- An op is accepted when IN_VALID=1 and STALL=0. All pulse outputs are 0 in any cycle following no accepted op.
- State machine on PFX_CNT: EMPTY (0), PARTIAL (1..MAX_PFX-1), FULL (MAX_PFX). Transitions:
  - PREFIX in EMPTY/PARTIAL: acc = {acc, INPUT} (shift in at LSB end); count+1.
  - PREFIX in FULL: oldest chunk shifted out; count stays; PFX_OVF pulses the next cycle; no OUT_VALID.
  - ZE/SE/HI in any state: produce a result, then count=0 and acc=0 (EMPTY).
- Result, with n = count at acceptance and V = {acc[n*IN_W-1:0], INPUT} of width (n+1)*IN_W:
  - ZE: V zero-extended to OUT_W.
  - SE: V sign-extended to OUT_W from bit (n+1)*IN_W-1.
  - HI: INPUT << (OUT_W-IN_W), low bits zero. Any prefix is discarded; PFX_DROP pulses if n>0.
- Latency: OUTPUT and OUT_VALID appear on the edge after acceptance (1 cycle); back-to-back ops give back-to-back pulses.
- Width arithmetic is exact: (MAX_PFX+1)*IN_W == OUT_W, so no truncation occurs.
- RESET asserted mid-chain loses the prefix; the next op after RESET deasserts sees EMPTY.

Decomposition:
- Shared package: MODE encodings (MODE_ZE, MODE_SE, MODE_HI, MODE_PFX) and the state encoding EMPTY/PARTIAL/FULL.
- One natural combinational sub-module: ext_core. It takes V, n and mode and returns the OUT_W result, so it can be unit-tested alongside the legacy zero-extender.
- The sequencer, accumulator and output register live in the top level.

Test Plan:
- Default params; ZE 0xAA, then SE 0xAA, then HI 0x47 on consecutive cycles → OUTPUT 0x00AA, 0xFFAA, 0x4700 on three consecutive edges, OUT_VALID high for all three.
- PREFIX 0x12, then ZE 0x34 → PFX_CNT=1 after the first op, no OUT_VALID; OUTPUT 0x1234 with OUT_VALID after the second; PFX_CNT back to 0.
- OUT_W=32: PREFIX 0x80, then SE 0x01 → OUTPUT 0xFFFF8001. PREFIX 0x80, then ZE 0x01 → 0x00008001.
- Default params: PREFIX 0x11, PREFIX 0x22, then ZE 0x33 → PFX_OVF pulses after the second PREFIX; OUTPUT 0x2233.
- PREFIX 0x55, then HI 0x01 → OUTPUT 0x0100 with PFX_DROP pulse. PREFIX 0x55, then FLUSH with ZE 0x01 → OUTPUT 0x0001.
- STALL held 3 cycles during PREFIX 0x12 / ZE 0x34 → no state change while stalled; result 0x1234 on the edge after STALL releases. RESET after a PREFIX → PFX_CNT=0, OUTPUT=0.
